// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing scheduler.
//   state_e : scheduler FSM states.
//   id_w()  : width of a requester index for a given requester count.
//   wd_w()  : width of the watchdog counter for a given timeout.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The watchdog only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    function automatic int wd_w(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_WD_W    = wd_w(DEF_TIMEOUT);

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: rotates the request vector so the pointer position
// sits at bit 0, picks the lowest set bit, then maps it back.
//   req     : request vector, one bit per requester.
//   ptr     : highest-priority requester index this round.
//   gnt     : one-hot grant (all zero when nothing requests).
//   gnt_idx : binary index of the granted requester.
//   gnt_any : at least one request present.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [id_w(NREQ)-1:0]   ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [id_w(NREQ)-1:0]   gnt_idx,
    output logic                    gnt_any
);

    localparam int              IDW    = id_w(NREQ);
    localparam logic [IDW:0]    NREQ_W = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [IDW-1:0]    off_s;
    logic [IDW:0]      sum_s;

    // Doubling the vector turns the rotate into a plain right shift.
    assign dbl_s   = {req, req};
    assign rot_s   = NREQ'(dbl_s >> ptr);
    assign gnt_any = |rot_s;

    // Priority encoder over the rotated vector; the lowest set bit wins.
    always_comb begin
        off_s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = IDW'(i);
            end else begin
                off_s = off_s;
            end
        end
    end

    // Undo the rotation: winner = (ptr + offset) mod NREQ.
    always_comb begin
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= NREQ_W) begin
            gnt_idx = IDW'(sum_s - NREQ_W);
        end else begin
            gnt_idx = IDW'(sum_s);
        end
    end

    assign gnt = gnt_any ? (NREQ'(1'b1) << gnt_idx) : '0;

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one signed WIDTH x WIDTH multiplier among
// NREQ requesters, with a watchdog that aborts a stalled multiplication.
//   Clk, Reset            : clock, asynchronous active-high reset.
//   req_valid/req_a/req_b : per-requester operand pairs; req_ready is the
//                           one-hot accept strobe (combinational, IDLE only).
//   mul_a/mul_b           : operands to the multiplier, held from ISSUE on.
//   mul_start/mul_abort   : single-cycle control pulses to the multiplier.
//   mul_done/mul_prod     : completion pulse and product from the multiplier.
//   rsp_valid/rsp_ready   : response handshake; rsp_id/rsp_prod/rsp_err carry
//                           requester index, product and timeout flag.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    output logic                    mul_start,
    output logic                    mul_abort,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_prod,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [id_w(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]      rsp_prod,
    output logic                    rsp_err
);

    localparam int             IDW     = id_w(NREQ);
    localparam int             WDW     = wd_w(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_e             state_r, state_s;
    logic [IDW-1:0]     ptr_r, ptr_nxt_s, id_r;
    logic [WDW-1:0]     wd_r;
    logic [WIDTH-1:0]   a_r, b_r, a_sel_s, b_sel_s;
    logic [2*WIDTH-1:0] prod_r;
    logic               err_r;
    logic [NREQ-1:0]    gnt_s;
    logic [IDW-1:0]     gnt_idx_s;
    logic               gnt_any_s;
    logic               accept_s, done_s, abort_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // AND-OR mux of the granted requester's operand slices.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel_s = a_sel_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
            b_sel_s = b_sel_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
        end
    end

    // Next-state logic plus accept/done/abort decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        done_s   = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_any_s) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                // A completion in the last watchdog cycle still counts as done.
                if (mul_done) begin
                    done_s  = 1'b1;
                    state_s = RESP;
                end else if (wd_r == WD_LAST) begin
                    abort_s = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next round starts just after the requester that was last served.
    assign ptr_nxt_s = (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);

    // Reset is folded in so no accept strobe leaks out while IDLE is forced.
    assign req_ready = (accept_s && !Reset) ? gnt_s : '0;
    assign mul_start = (state_r == ISSUE);
    assign mul_abort = abort_s;
    assign rsp_valid = (state_r == RESP);
    assign mul_a     = a_r;
    assign mul_b     = b_r;
    assign rsp_id    = id_r;
    assign rsp_prod  = prod_r;
    assign rsp_err   = err_r;

    // State, pointer, watchdog, operand and response registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            wd_r    <= '0;
            id_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            prod_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                id_r <= gnt_idx_s;
                a_r  <= a_sel_s;
                b_r  <= b_sel_s;
            end
            if (state_r == ISSUE) begin
                wd_r <= '0;
            end else if (state_r == WAIT) begin
                wd_r <= wd_r + WDW'(1);
            end
            if (done_s) begin
                prod_r <= mul_prod;
                err_r  <= 1'b0;
            end else if (abort_s) begin
                prod_r <= '0;
                err_r  <= 1'b1;
            end
            if ((state_r == RESP) && rsp_ready) begin
                ptr_r <= ptr_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: the bench plays the multiplier
// and the requesters, and predicts grants/products with a plain round-robin
// model (pointer + scan) and integer multiplication.
module tb_mult_share_ctrl;

    localparam int NREQ = 4, WIDTH = 8, TIMEOUT = 64;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a, mul_b;
    logic        mul_start, mul_abort, mul_done;
    logic [15:0] mul_prod;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_prod;
    logic        rsp_err;

    mult_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_abort(mul_abort), .mul_done(mul_done), .mul_prod(mul_prod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err)
    );

    always #5 Clk = ~Clk;

    int checks = 0, failures = 0;
    int model_ptr = 0;

    // Observations of the last transaction
    int          e_g, o_acc_wait, o_start_k, o_start_cnt, o_abort_k, o_abort_cnt, o_rsp_k;
    logic [3:0]  o_gnt;
    logic [1:0]  o_id;
    logic [15:0] o_prod, e_prod;
    logic        o_err;
    bit          o_unstable, o_ready_bad, o_op_bad;

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, p;
        pa = int'($signed(a));
        pb = int'($signed(b));
        p  = pa * pb;
        return p[15:0];
    endfunction

    // One full transaction; lat<0 means the multiplier never finishes.
    task automatic do_txn(input logic [3:0] vld, input logic [31:0] a_all, input logic [31:0] b_all,
                          input int lat, input int bp, input bit keep_valid);
        logic [7:0] e_a, e_b;
        bit hs;
        e_g = -1;
        for (int j = 0; j < NREQ; j++) begin
            int c;
            c = (model_ptr + j) % NREQ;
            if (e_g < 0 && vld[c]) e_g = c;
        end
        e_a = a_all[e_g*8 +: 8];
        e_b = b_all[e_g*8 +: 8];
        e_prod = smul(e_a, e_b);
        o_acc_wait = -1; o_start_k = -1; o_start_cnt = 0; o_abort_k = -1; o_abort_cnt = 0;
        o_rsp_k = -1; o_unstable = 0; o_ready_bad = 0; o_op_bad = 0; hs = 0;
        o_id = '0; o_prod = '0; o_err = 1'b0;
        @(negedge Clk);
        req_valid = vld; req_a = a_all; req_b = b_all;
        for (int w = 0; w < 8; w++) begin
            #1;
            if (req_ready != 4'b0) begin o_acc_wait = w; break; end
            @(negedge Clk);
        end
        o_gnt = req_ready;
        if (o_acc_wait < 0) begin req_valid = 4'b0; return; end
        @(posedge Clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clk);
            if (!keep_valid) req_valid = 4'b0;
            if (hs) begin rsp_ready = 1'b0; req_valid = 4'b0; break; end
            mul_done = (lat >= 0 && k == 1 + lat);
            mul_prod = mul_done ? e_prod : 16'($urandom);
            #1;
            if (req_ready != 4'b0) o_ready_bad = 1;
            if (mul_start) begin o_start_cnt++; o_start_k = k; end
            if (mul_abort) begin o_abort_cnt++; o_abort_k = k; end
            if (rsp_valid) begin
                if (o_rsp_k < 0) begin
                    o_rsp_k = k; o_id = rsp_id; o_prod = rsp_prod; o_err = rsp_err;
                end else if (rsp_id !== o_id || rsp_prod !== o_prod || rsp_err !== o_err) begin
                    o_unstable = 1;
                end
                if (k - o_rsp_k >= bp) begin rsp_ready = 1'b1; hs = 1; end
            end else begin
                if (o_rsp_k >= 0) o_unstable = 1;
                if (mul_a !== e_a || mul_b !== e_b) o_op_bad = 1;
            end
        end
        mul_done = 1'b0; rsp_ready = 1'b0; req_valid = 4'b0;
        if (hs) model_ptr = (e_g + 1) % NREQ;
    endtask

    task automatic test_reset();
        Reset = 1'b1; req_valid = 4'b1111; req_a = 32'h11223344; req_b = 32'h55667788;
        mul_done = 1'b0; mul_prod = 16'h0; rsp_ready = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if ({mul_a, mul_b, mul_start, mul_abort, rsp_valid, rsp_id, rsp_prod, rsp_err} !== 37'b0) begin
            failures++; $display("FAIL reset_outputs got %h exp 0", {mul_a, mul_b, mul_start, mul_abort, rsp_valid, rsp_id, rsp_prod, rsp_err}); end
        @(negedge Clk);
        Reset = 1'b0; req_valid = 4'b0;
        model_ptr = 0;
    endtask

    task automatic test_contention();
        logic [3:0] vl [4] = '{4'b0110, 4'b0110, 4'b0011, 4'b0011};
        int         ex [4] = '{1, 2, 0, 1};
        for (int t = 0; t < 4; t++) begin
            do_txn(vl[t], $urandom, $urandom, $urandom_range(1, 8), 0, 0);
            checks++; if (e_g !== ex[t]) begin failures++; $display("FAIL contention_model_%0d got %0d exp %0d", t, e_g, ex[t]); end
            checks++; if (o_gnt !== 4'(1 << ex[t])) begin failures++; $display("FAIL contention_grant_%0d got %b exp %b", t, o_gnt, 4'(1 << ex[t])); end
            checks++; if (o_id !== 2'(ex[t]) || o_prod !== e_prod || o_err !== 1'b0) begin
                failures++; $display("FAIL contention_rsp_%0d got id=%0d prod=%h err=%b exp id=%0d prod=%h err=0", t, o_id, o_prod, o_err, ex[t], e_prod); end
        end
    endtask

    task automatic test_single();
        do_txn(4'b0001, 32'h00000007, 32'h000000FD, 16, 0, 0);
        checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL single_grant got %b exp 0001", o_gnt); end
        checks++; if (o_start_cnt !== 1 || o_start_k !== 1) begin failures++; $display("FAIL single_start got cnt=%0d k=%0d exp cnt=1 k=1", o_start_cnt, o_start_k); end
        checks++; if (o_op_bad) begin failures++; $display("FAIL single_operands got unstable exp a=07 b=fd"); end
        checks++; if (o_rsp_k !== 18) begin failures++; $display("FAIL single_latency got %0d exp 18", o_rsp_k); end
        checks++; if (o_id !== 2'd0 || o_prod !== 16'hFFEB || o_err !== 1'b0) begin
            failures++; $display("FAIL single_rsp got id=%0d prod=%h err=%b exp id=0 prod=ffeb err=0", o_id, o_prod, o_err); end
    endtask

    task automatic test_backpressure();
        do_txn(4'b1111, $urandom, $urandom, 4, 5, 1);
        checks++; if (o_unstable) begin failures++; $display("FAIL bp_stable got changed exp stable"); end
        checks++; if (o_ready_bad) begin failures++; $display("FAIL bp_req_ready got nonzero exp 0000"); end
        checks++; if (o_prod !== e_prod || o_id !== 2'(e_g)) begin failures++; $display("FAIL bp_rsp got id=%0d prod=%h exp id=%0d prod=%h", o_id, o_prod, e_g, e_prod); end
        do_txn(4'b1111, $urandom, $urandom, 2, 0, 0);
        checks++; if (o_gnt !== 4'(1 << e_g) || o_acc_wait !== 0) begin failures++; $display("FAIL bp_next_grant got %b exp %b", o_gnt, 4'(1 << e_g)); end
    endtask

    task automatic test_timeout();
        do_txn(4'b0100, $urandom, $urandom, -1, 0, 0);
        checks++; if (o_abort_cnt !== 1 || o_abort_k - o_start_k !== TIMEOUT) begin
            failures++; $display("FAIL timeout_abort got cnt=%0d delay=%0d exp cnt=1 delay=%0d", o_abort_cnt, o_abort_k - o_start_k, TIMEOUT); end
        checks++; if (o_err !== 1'b1 || o_prod !== 16'h0 || o_id !== 2'd2) begin
            failures++; $display("FAIL timeout_rsp got id=%0d prod=%h err=%b exp id=2 prod=0000 err=1", o_id, o_prod, o_err); end
        do_txn(4'b0100, $urandom, $urandom, 3, 0, 0);
        checks++; if (o_err !== 1'b0 || o_prod !== e_prod || o_abort_cnt !== 0) begin
            failures++; $display("FAIL timeout_recover got prod=%h err=%b aborts=%0d exp prod=%h err=0 aborts=0", o_prod, o_err, o_abort_cnt, e_prod); end
    endtask

    task automatic test_extremes();
        @(negedge Clk); mul_done = 1'b1; mul_prod = 16'hBEEF;
        @(negedge Clk); mul_done = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0 || mul_start !== 1'b0) begin failures++; $display("FAIL stray_done got rsp_valid=%b exp 0", rsp_valid); end
        do_txn(4'b1000, 32'h80000000, 32'h80000000, 5, 0, 0);
        checks++; if (o_prod !== 16'h4000 || o_err !== 1'b0) begin failures++; $display("FAIL extreme_prod got %h exp 4000", o_prod); end
        do_txn(4'b0010, $urandom, $urandom, TIMEOUT, 0, 0);
        checks++; if (o_err !== 1'b0 || o_abort_cnt !== 0 || o_prod !== e_prod) begin
            failures++; $display("FAIL collide got err=%b aborts=%0d prod=%h exp err=0 aborts=0 prod=%h", o_err, o_abort_cnt, o_prod, e_prod); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            int lat;
            lat = $urandom_range(1, 20);
            do_txn(4'($urandom_range(1, 15)), $urandom, $urandom, lat, $urandom_range(0, 2), 0);
            checks++; if (o_gnt !== 4'(1 << e_g)) begin failures++; $display("FAIL rand_grant_%0d got %b exp %b", t, o_gnt, 4'(1 << e_g)); end
            checks++; if (o_id !== 2'(e_g) || o_prod !== e_prod || o_err !== 1'b0) begin
                failures++; $display("FAIL rand_rsp_%0d got id=%0d prod=%h err=%b exp id=%0d prod=%h err=0", t, o_id, o_prod, o_err, e_g, e_prod); end
            checks++; if (o_rsp_k !== lat + 2 || o_op_bad || o_unstable || o_ready_bad) begin
                failures++; $display("FAIL rand_timing_%0d got rsp_k=%0d opbad=%0d exp rsp_k=%0d opbad=0", t, o_rsp_k, o_op_bad, lat + 2); end
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge Clk); req_valid = 4'b0100; req_a = 32'h00A50000; req_b = 32'h005A0000;
        @(negedge Clk); req_valid = 4'b0;
        repeat (4) @(negedge Clk);
        #2; Reset = 1'b1; req_valid = 4'b1111;
        #1;
        checks++; if ({req_ready, mul_a, mul_b, mul_start, mul_abort, rsp_valid, rsp_id, rsp_prod, rsp_err} !== 41'b0) begin
            failures++; $display("FAIL rstwait_outputs got %h exp 0", {req_ready, mul_a, mul_b, mul_start, mul_abort, rsp_valid, rsp_id, rsp_prod, rsp_err}); end
        @(negedge Clk); #1;
        checks++; if (req_ready !== 4'b0 || mul_start !== 1'b0) begin failures++; $display("FAIL rstwait_held got ready=%b exp 0000", req_ready); end
        Reset = 1'b0; req_valid = 4'b0;
        model_ptr = 0;
        do_txn(4'b1001, $urandom, $urandom, 2, 0, 0);
        checks++; if (o_gnt !== 4'b0001 || o_id !== 2'd0 || o_prod !== e_prod) begin
            failures++; $display("FAIL rstwait_grant got %b id=%0d exp 0001 id=0", o_gnt, o_id); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_timeout();
        test_extremes();
        test_random();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
